regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-back controller for the 32×32 two-read/one-write register file. It shares the single write port between several write-back requesters (ALU, load, mult/div) using round-robin arbitration and a valid/ready handshake. It registers the winning write onto the register file's write-port signals and keeps a pending-write scoreboard that flags read hazards on both read ports.

## Interface
Parameters:
- NREQ, 3, number of write-back requesters (2..4)
- DATA_W, 32, register data width
- ADDR_W, 5, register index width

Ports:
- clock  in  1  single clock; all state updates on the rising edge
- ctrl_reset  in  1  reset, asynchronous, active-high
- req_valid  in  NREQ  requester i holds a write
- req_reg  in  NREQ×ADDR_W  destination index per requester
- req_data  in  NREQ×DATA_W  write data per requester
- req_ready  out  NREQ  grant; a transfer occurs when req_valid[i] and req_ready[i] are both high
- rsv_valid  in  1  issue-time reservation of a destination register
- rsv_reg  in  ADDR_W  reserved register index
- ctrl_readRegA, ctrl_readRegB  in  ADDR_W  read indices presented to the register file
- ctrl_writeEnable  out  1  to the register file write enable
- ctrl_writeReg  out  ADDR_W  to the register file write index
- data_writeReg  out  DATA_W  to the register file write data
- stall_a, stall_b  out  1  the read index is pending
- pending  out  32  scoreboard mask
- err_dup_rsv  out  1  sticky flag: a reservation was made on an already-pending register

## Operation
- **Arbitration:** combinational round-robin from the pointer `rr_ptr`.
  - Scan starts at `rr_ptr` and wraps at NREQ-1 to 0.
  - The first requester with `req_valid` high gets `req_ready`.
  - At most one `req_ready` is high per cycle.
  - No valid requesters means no ready.
- **Pointer update:** on a transfer from requester g, `rr_ptr` becomes (g+1) mod NREQ. With no transfer, `rr_ptr` holds.
- **Requester obligation:** once `req_valid` is asserted, it stays asserted with `req_reg` and `req_data` stable until the transfer. The bench checks this with an assertion.
- **Output stage:**
  - On a transfer, `ctrl_writeReg` and `data_writeReg` load the granted requester's values.
  - `ctrl_writeEnable` is set to 1 unless `req_reg` is 0. Writes to r0 are accepted but suppressed, so `ctrl_writeEnable` stays 0.
  - With no transfer, `ctrl_writeEnable` is 0 and the index/data outputs hold.
- **Scoreboard (`pending`):**
  - Set: `rsv_valid` with nonzero `rsv_reg` sets `pending[rsv_reg]` at the edge.
  - Clear: `pending[ctrl_writeReg]` clears at the edge that ends a cycle with `ctrl_writeEnable` high. That is the same edge on which the register file captures the data.
  - Set and clear on the same register in the same cycle: set wins.
  - `pending[0]` is constant 0.
  - Reserving a register whose bit is already set leaves it set and sets `err_dup_rsv`. The flag is cleared only by reset.
- **Hazard outputs:** `stall_a` = `pending[ctrl_readRegA]` and `stall_b` = `pending[ctrl_readRegB]`, both combinational. Index 0 never stalls.

## Timing
- **Reset** (asynchronous, immediate):
  - `rr_ptr` = 0, `pending` = 0, `err_dup_rsv` = 0.
  - `ctrl_writeEnable` = 0, `ctrl_writeReg` = 0, `data_writeReg` = 0.
  - `req_ready` is 0 while reset is asserted.
- **Reset mid-operation:** an accepted write that has not yet appeared on the outputs is discarded, and all pending bits are lost.
- **Latency:** transfer in cycle N, then `ctrl_writeEnable` is high in cycle N+1, the register file captures at the end of N+1, and the `pending` bit is clear in N+2.
- **Throughput:** one write per cycle, sustained. `req_ready` does not depend on any downstream backpressure, because the register file always accepts.
- **Stall timing:** a reservation in cycle N gives `stall` high from N+1.

## Structure
- **Shared package `regfile_pkg`:**
  - REG_COUNT = 32, ADDR_W = 5, DATA_W = 32, ZERO_REG = 0.
  - Requester index constants: REQ_ALU = 0, REQ_LOAD = 1, REQ_MULTDIV = 2.
- **Sub-module `rr_arbiter`:** inputs are the NREQ request vector and `rr_ptr`; outputs are a one-hot grant and the encoded grant index. It is purely combinational, and the pointer register stays in the parent.
- **Parent:** holds the pointer, output register, scoreboard and error flag.

## Test plan
- Reset released, no requests: all outputs 0 for 10 cycles. Apply `ctrl_reset` mid-burst: outputs and `pending` are 0 in the same cycle.
- Single write: requester 1 holds reg 7, data 0xDEADBEEF. `req_ready[1]` is high in cycle N; in N+1 the outputs are `ctrl_writeEnable` = 1, `ctrl_writeReg` = 7, `data_writeReg` = 0xDEADBEEF; in N+2 `ctrl_writeEnable` = 0.
- All three valid continuously with distinct registers 3/4/5: grants go 0,1,2,0,1,2 with one write per cycle, and none is dropped or duplicated.
- Write to r0 with data 0x12345678: `req_ready` is high, `ctrl_writeEnable` stays 0, and `pending[0]` stays 0.
- Scoreboard round trip:
  - Reserve reg 9 in cycle N, with `ctrl_readRegA` = 9: `stall_a` = 1 from N+1.
  - Write reg 9 is accepted in M: `stall_a` = 0 from M+2.
  - Reserve reg 9 again in M+1 (same cycle the write is on the outputs): `stall_a` stays 1 and `err_dup_rsv` = 1.
- Reserve reg 0: `pending` is unchanged and `err_dup_rsv` stays 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-back path.
// Holds the register-file geometry, the fixed requester slot assignments
// and a small helper for sizing requester index fields.
package regfile_pkg;

  localparam int REG_COUNT = 32;
  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 32;
  localparam int ZERO_REG  = 0;

  // Write-back requester slots
  localparam int REQ_ALU     = 0;
  localparam int REQ_LOAD    = 1;
  localparam int REQ_MULTDIV = 2;

  // Width of an index able to address n requesters (at least one bit)
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// Combinational round-robin arbiter for the write-back requesters.
// Ports:
//   req       - request vector, one bit per requester
//   ptr       - requester with the highest priority this cycle
//   grant     - one-hot grant (all zero when nobody requests)
//   grant_idx - encoded index of the granted requester (0 when none)
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ  = 3,
  parameter int IDX_W = idx_width(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic             found;
  logic [IDX_W-1:0] idx;
  int               sum;

  // Walk the requesters starting at ptr, wrapping past NREQ-1, and take
  // the first one that is asking.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    sum       = 0;
    for (int i = 0; i < NREQ; i++) begin
      sum = int'(ptr) + i;
      if (sum >= NREQ) sum = sum - NREQ;
      idx = IDX_W'(sum);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back controller for the 32x32 register file.
// Shares the single write port between NREQ requesters with round-robin
// arbitration, registers the winning write onto the write-port signals and
// tracks pending destination registers to flag read hazards.
// Ports:
//   clock, ctrl_reset                     - clock, async active-high reset
//   req_valid/req_reg/req_data/req_ready  - per-requester write handshake
//   rsv_valid, rsv_reg                    - issue-time destination reservation
//   ctrl_readRegA, ctrl_readRegB          - read indices being looked up
//   ctrl_writeEnable/ctrl_writeReg/data_writeReg - register file write port
//   stall_a, stall_b                      - read index is still pending
//   pending                               - pending-write scoreboard
//   err_dup_rsv                           - sticky duplicate-reservation flag
module regfile_wb_arbiter #(
  parameter int NREQ   = 3,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                        clock,
  input  logic                        ctrl_reset,
  input  logic [NREQ-1:0]             req_valid,
  input  logic [NREQ-1:0][ADDR_W-1:0] req_reg,
  input  logic [NREQ-1:0][DATA_W-1:0] req_data,
  output logic [NREQ-1:0]             req_ready,
  input  logic                        rsv_valid,
  input  logic [ADDR_W-1:0]           rsv_reg,
  input  logic [ADDR_W-1:0]           ctrl_readRegA,
  input  logic [ADDR_W-1:0]           ctrl_readRegB,
  output logic                        ctrl_writeEnable,
  output logic [ADDR_W-1:0]           ctrl_writeReg,
  output logic [DATA_W-1:0]           data_writeReg,
  output logic                        stall_a,
  output logic                        stall_b,
  output logic [regfile_pkg::REG_COUNT-1:0] pending,
  output logic                        err_dup_rsv
);

  import regfile_pkg::*;

  localparam int IDX_W = idx_width(NREQ);

  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     ptr_next;
  logic [NREQ-1:0]      grant;
  logic [IDX_W-1:0]     grant_idx;
  logic                 transfer;
  logic                 rsv_set;
  logic [REG_COUNT-1:0] pending_next;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // The register file always accepts, so a grant is a transfer; ready is
  // forced low while reset is held.
  assign req_ready = ctrl_reset ? '0 : grant;
  assign transfer  = |grant;

  // Priority moves to the requester just after the one served
  always_comb begin
    ptr_next = rr_ptr;
    if (grant_idx == IDX_W'(NREQ - 1)) ptr_next = '0;
    else                               ptr_next = grant_idx + IDX_W'(1);
  end

  // Pointer and registered write port. Writes to r0 still load index and
  // data but never raise the write enable.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      rr_ptr           <= '0;
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= '0;
      data_writeReg    <= '0;
    end else if (transfer) begin
      rr_ptr           <= ptr_next;
      ctrl_writeEnable <= (req_reg[grant_idx] != ADDR_W'(ZERO_REG));
      ctrl_writeReg    <= req_reg[grant_idx];
      data_writeReg    <= req_data[grant_idx];
    end else begin
      ctrl_writeEnable <= 1'b0;
    end
  end

  assign rsv_set = rsv_valid && (rsv_reg != ADDR_W'(ZERO_REG));

  // A write on the port clears its bit at the edge the register file
  // captures it; a reservation in the same cycle is applied afterwards so
  // it wins.
  always_comb begin
    pending_next = pending;
    if (ctrl_writeEnable) pending_next[ctrl_writeReg] = 1'b0;
    if (rsv_set)          pending_next[rsv_reg]       = 1'b1;
    pending_next[ZERO_REG] = 1'b0;
  end

  // Scoreboard state and the sticky duplicate-reservation flag
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      pending     <= '0;
      err_dup_rsv <= 1'b0;
    end else begin
      pending <= pending_next;
      if (rsv_set && pending[rsv_reg]) err_dup_rsv <= 1'b1;
    end
  end

  assign stall_a = pending[ctrl_readRegA];
  assign stall_b = pending[ctrl_readRegB];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed steps with a small
// reference model and an expected-write queue compared one cycle later.
module tb_regfile_wb_arbiter;

  localparam int NREQ = 3;

  typedef struct {
    logic        we;
    logic [4:0]  rg;
    logic [31:0] data;
  } wr_t;

  logic                 clock = 1'b0;
  logic                 ctrl_reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0][4:0] req_reg;
  logic [NREQ-1:0][31:0] req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 rsv_valid;
  logic [4:0]           rsv_reg;
  logic [4:0]           ctrl_readRegA;
  logic [4:0]           ctrl_readRegB;
  logic                 ctrl_writeEnable;
  logic [4:0]           ctrl_writeReg;
  logic [31:0]          data_writeReg;
  logic                 stall_a;
  logic                 stall_b;
  logic [31:0]          pending;
  logic                 err_dup_rsv;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  int          m_ptr;
  logic [31:0] m_pending;
  logic        m_err;
  logic        m_we;
  logic [4:0]  m_reg;
  logic [31:0] m_data;
  wr_t         exp_q[$];

  regfile_wb_arbiter #(.NREQ(NREQ), .DATA_W(32), .ADDR_W(5)) dut (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .req_valid        (req_valid),
    .req_reg          (req_reg),
    .req_data         (req_data),
    .req_ready        (req_ready),
    .rsv_valid        (rsv_valid),
    .rsv_reg          (rsv_reg),
    .ctrl_readRegA    (ctrl_readRegA),
    .ctrl_readRegB    (ctrl_readRegB),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .stall_a          (stall_a),
    .stall_b          (stall_b),
    .pending          (pending),
    .err_dup_rsv      (err_dup_rsv)
  );

  always #5 clock = ~clock;

  // A requester left waiting must keep valid, index and data unchanged
  logic [NREQ-1:0]       prev_valid;
  logic [NREQ-1:0]       prev_ready;
  logic [NREQ-1:0][4:0]  prev_reg;
  logic [NREQ-1:0][31:0] prev_data;
  logic                  prev_rst = 1'b1;

  always @(negedge clock) begin
    if (!ctrl_reset && !prev_rst) begin
      for (int i = 0; i < NREQ; i++) begin
        if (prev_valid[i] && !prev_ready[i]) begin
          assert (req_valid[i] && req_reg[i] === prev_reg[i] && req_data[i] === prev_data[i])
          else begin
            miscompares++;
            $error("[TB] FAIL hold_rule req%0d: observed valid=%b reg=%0d expected valid=1 reg=%0d",
                   i, req_valid[i], req_reg[i], prev_reg[i]);
          end
        end
      end
    end
    prev_valid <= req_valid;
    prev_ready <= req_ready;
    prev_reg   <= req_reg;
    prev_data  <= req_data;
    prev_rst   <= ctrl_reset;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic rv,
                               input logic [4:0] rr);
    req_valid = valid;
    rsv_valid = rv;
    rsv_reg   = rr;
  endtask

  task automatic setReq(input int i, input logic [4:0] rg, input logic [31:0] data);
    req_reg[i]  = rg;
    req_data[i] = data;
  endtask

  task automatic modelReset();
    m_ptr     = 0;
    m_pending = '0;
    m_err     = 1'b0;
    m_we      = 1'b0;
    m_reg     = '0;
    m_data    = '0;
    exp_q.delete();
  endtask

  // One clock cycle: check combinational outputs mid-cycle against the
  // model, push the expected write, then pop and compare after the edge.
  task automatic stepCycle();
    int              g;
    logic [NREQ-1:0] exp_ready;
    logic [31:0]     nxt;
    wr_t             e;
    wr_t             got;
    @(negedge clock);
    g = -1;
    for (int i = 0; i < NREQ; i++) begin
      int k;
      k = (m_ptr + i) % NREQ;
      if (g < 0 && req_valid[k]) g = k;
    end
    exp_ready = (g < 0) ? '0 : NREQ'(1 << g);
    checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
    checkOutput("stall_a", 32'(stall_a), 32'(m_pending[ctrl_readRegA]));
    checkOutput("stall_b", 32'(stall_b), 32'(m_pending[ctrl_readRegB]));
    nxt = m_pending;
    if (m_we) nxt[m_reg] = 1'b0;
    if (rsv_valid && rsv_reg != 5'd0) begin
      if (m_pending[rsv_reg]) m_err = 1'b1;
      nxt[rsv_reg] = 1'b1;
    end
    m_pending = nxt;
    if (g >= 0) begin
      e.we   = (req_reg[g] != 5'd0);
      e.rg   = req_reg[g];
      e.data = req_data[g];
      m_ptr  = (g + 1) % NREQ;
    end else begin
      e.we   = 1'b0;
      e.rg   = m_reg;
      e.data = m_data;
    end
    m_we   = e.we;
    m_reg  = e.rg;
    m_data = e.data;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    got = exp_q.pop_front();
    checkOutput("writeEnable", 32'(ctrl_writeEnable), 32'(got.we));
    checkOutput("writeReg", 32'(ctrl_writeReg), 32'(got.rg));
    checkOutput("writeData", data_writeReg, got.data);
    checkOutput("pending", pending, m_pending);
    checkOutput("err_dup_rsv", 32'(err_dup_rsv), 32'(m_err));
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must clear at once
  task automatic doReset();
    #2 ctrl_reset = 1'b1;
    #1;
    checkOutput("rst_we", 32'(ctrl_writeEnable), 32'd0);
    checkOutput("rst_reg", 32'(ctrl_writeReg), 32'd0);
    checkOutput("rst_data", data_writeReg, 32'd0);
    checkOutput("rst_pending", pending, 32'd0);
    checkOutput("rst_err", 32'(err_dup_rsv), 32'd0);
    checkOutput("rst_ready", 32'(req_ready), 32'd0);
    modelReset();
    @(posedge clock);
    #1 ctrl_reset = 1'b0;
  endtask

  initial begin
    logic [NREQ-1:0] v;
    ctrl_reset    = 1'b1;
    req_valid     = '0;
    req_reg       = '0;
    req_data      = '0;
    rsv_valid     = 1'b0;
    rsv_reg       = '0;
    ctrl_readRegA = 5'd9;
    ctrl_readRegB = 5'd20;
    modelReset();

    // Power-on reset, then an idle stretch
    repeat (2) @(posedge clock);
    #1;
    checkOutput("por_we", 32'(ctrl_writeEnable), 32'd0);
    checkOutput("por_pending", pending, 32'd0);
    checkOutput("por_ready", 32'(req_ready), 32'd0);
    ctrl_reset = 1'b0;
    repeat (10) stepCycle();

    // Single write from requester 1
    setReq(1, 5'd7, 32'hDEADBEEF);
    applyStimulus(3'b010, 1'b0, 5'd0);
    stepCycle();
    checkOutput("single_we", 32'(ctrl_writeEnable), 32'd1);
    checkOutput("single_reg", 32'(ctrl_writeReg), 32'd7);
    checkOutput("single_data", data_writeReg, 32'hDEADBEEF);
    applyStimulus(3'b000, 1'b0, 5'd0);
    stepCycle();
    checkOutput("single_we_drop", 32'(ctrl_writeEnable), 32'd0);

    // Burst with a reservation, interrupted by reset
    for (int i = 0; i < NREQ; i++) setReq(i, 5'(3 + i), 32'hA0 + 32'(i));
    applyStimulus(3'b111, 1'b1, 5'd20);
    stepCycle();
    checkOutput("burst_stall_b", 32'(stall_b), 32'd1);
    applyStimulus(3'b111, 1'b0, 5'd0);
    stepCycle();
    stepCycle();
    doReset();

    // Fresh burst: grants rotate 0,1,2; each requester drops after its
    // grant once two full rounds are done
    v = 3'b111;
    for (int i = 0; i < 9; i++) begin
      stepCycle();
      checkOutput("grant_order", 32'(ctrl_writeReg), 32'(3 + (i % 3)));
      if (i >= 6) v[i % 3] = 1'b0;
      applyStimulus(v, 1'b0, 5'd0);
    end

    // Write to r0 is accepted but suppressed
    setReq(0, 5'd0, 32'h12345678);
    applyStimulus(3'b001, 1'b0, 5'd0);
    stepCycle();
    checkOutput("r0_we", 32'(ctrl_writeEnable), 32'd0);
    checkOutput("r0_data", data_writeReg, 32'h12345678);
    checkOutput("r0_pending0", 32'(pending[0]), 32'd0);
    applyStimulus(3'b000, 1'b0, 5'd0);
    stepCycle();

    // Reserving r0 changes nothing
    applyStimulus(3'b000, 1'b1, 5'd0);
    stepCycle();
    checkOutput("rsv_r0_pending", pending, 32'd0);
    checkOutput("rsv_r0_err", 32'(err_dup_rsv), 32'd0);

    // Scoreboard round trip on reg 9
    applyStimulus(3'b000, 1'b1, 5'd9);
    stepCycle();
    checkOutput("stall_a_n1", 32'(stall_a), 32'd1);
    applyStimulus(3'b000, 1'b0, 5'd0);
    stepCycle();
    setReq(2, 5'd9, 32'h99);
    applyStimulus(3'b100, 1'b0, 5'd0);
    stepCycle();
    checkOutput("stall_a_m1", 32'(stall_a), 32'd1);
    applyStimulus(3'b000, 1'b0, 5'd0);
    stepCycle();
    checkOutput("stall_a_m2", 32'(stall_a), 32'd0);

    // Re-reserve on the cycle the write is on the port: set wins, flag set
    applyStimulus(3'b000, 1'b1, 5'd9);
    stepCycle();
    setReq(2, 5'd9, 32'h77);
    applyStimulus(3'b100, 1'b0, 5'd0);
    stepCycle();
    checkOutput("rerv_we", 32'(ctrl_writeEnable), 32'd1);
    applyStimulus(3'b000, 1'b1, 5'd9);
    stepCycle();
    checkOutput("rerv_stall_a", 32'(stall_a), 32'd1);
    checkOutput("rerv_err", 32'(err_dup_rsv), 32'd1);
    applyStimulus(3'b000, 1'b0, 5'd0);
    stepCycle();
    checkOutput("rerv_stall_hold", 32'(stall_a), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
